array_3d_serializer: RTL and testbench
======================================

Name: array_3d_serializer

Overview:
- Downstream consumer of a 3D unpacked int array: snapshots the whole array on `start`, then streams elements one per handshake in nested-loop order (i outer, j middle, k inner, all ascending from 0).
- Each beat carries the element plus its (i,j,k) coordinates and a last flag.
- Sits after the stage that fills the array, turning stored contents into a beat stream for waveform and checker consumers.

Parameters:
- DIM_I, 4, size of dimension 1 (outermost index i)
- DIM_J, 3, size of dimension 2 (index j)
- DIM_K, 2, size of dimension 3 (innermost index k)
- DW, 32, element width (int)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request snapshot + stream; honoured only in IDLE
- array_in  in  DW x [DIM_I][DIM_J][DIM_K] unpacked  source array, sampled only on accepted start
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses
- out_valid  out  1  beat valid
- out_ready  in  1  consumer ready
- out_data  out  DW  element value
- out_i  out  IW=$clog2(DIM_I) (min 1)  coordinate i
- out_j  out  JW  coordinate j, same sizing rule
- out_k  out  KW  coordinate k, same sizing rule
- out_last  out  1  high on the final beat (i=DIM_I-1, j=DIM_J-1, k=DIM_K-1)
- done  out  1  single-cycle pulse after the final beat transfers

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, out_valid, out_last, done, out_data and coordinates all 0; snapshot contents don't-care.
- FSM IDLE -> STREAM -> DONE -> IDLE:
  - IDLE: start=1 copies array_in into the internal snapshot, clears counters and moves to STREAM at the next edge.
  - STREAM: out_valid=1. out_data = snap[i][j][k], combinational from registered counters.
  - Transfer occurs when out_valid & out_ready. On transfer k++; k wraps at DIM_K-1 -> 0 with j++; j wraps at DIM_J-1 -> 0 with i++.
  - Transfer with out_last=1 moves to DONE.
  - DONE: out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- Latency: first beat is valid 1 cycle after the accepted start. With out_ready held high, one beat per cycle and DIM_I*DIM_J*DIM_K beats total.
- Backpressure: while out_valid=1 and out_ready=0, out_data, coordinates and out_last hold stable.
- start is ignored in STREAM and DONE. It does not queue. array_in changes after the snapshot do not affect the stream.
- start=1 in the same cycle as done: ignored. Earliest accepted start is the following cycle, in IDLE.
- Degenerate sizes: any dimension equal to 1 is legal and its counter stays 0. A 1x1x1 array gives one beat with out_last=1.
- rst_n asserted mid-stream: aborts immediately. No done pulse; outputs go to reset values.

Optional Feature:
- Macro ARRAY_3D_SERIALIZER_CHECKSUM_EN.
- Defined:
  - Adds output `checksum` (out, DW), a registered wrap-around sum of out_data over transferred beats.
  - Cleared to 0 on reset and on accepted start.
  - Valid, and stable until the next accepted start, from the cycle done pulses.
- Undefined: the port and the adder do not exist; all other behaviour is identical.

Decomposition:
- Package array_3d_pkg holds:
  - default dimension constants DIM_I/DIM_J/DIM_K/DW;
  - the index-width function (clog2 with a minimum of 1);
  - the state enum typedef {IDLE, STREAM, DONE}.
- One sub-module, array_3d_index_counter: the three cascaded wrapping counters with advance input and wrap/last outputs. It is reusable by the upstream fill stage.

Test Plan:
- array_in[i][j][k]=i+j+k, start, out_ready=1 -> 24 beats on consecutive cycles. Beat 0 = (0,0,0) data 0; beat 1 = (0,0,1) data 1; beat 23 = (3,2,1) data 6 with out_last=1. done pulses the next cycle.
- Same stimulus, out_ready toggled 1,0,0,1 repeating -> same 24-beat sequence; outputs stable on every stalled cycle.
- Change array_in to all 0xFFFF_FFFF one cycle after start -> streamed data is still i+j+k, unaffected.
- Pulse start on the 5th beat while busy -> ignored: beat count stays 24 and no second stream follows.
- Drop rst_n after beat 10 -> out_valid, busy and done go to 0 asynchronously. A new start after release streams from (0,0,0).
- With ARRAY_3D_SERIALIZER_CHECKSUM_EN and the i+j+k pattern -> checksum = 72 when done pulses.

Source files
------------

// File: rtl/array_3d_serializer_pkg.sv
// Shared constants, index-width helper and FSM states
// for the 3D array serializer.
package array_3d_pkg;

  localparam int DIM_I = 4;
  localparam int DIM_J = 3;
  localparam int DIM_K = 2;
  localparam int DW    = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

endpackage

// File: rtl/array_3d_serializer_if.sv
// Beat stream bundle: element, (i,j,k) coordinates,
// last flag and valid/ready handshake.
interface array_3d_serializer_if #(
  parameter int DW = array_3d_pkg::DW,
  parameter int IW = 2,
  parameter int JW = 2,
  parameter int KW = 1
);

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_i;
  logic [JW-1:0] out_j;
  logic [KW-1:0] out_k;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_i,
    output out_j,
    output out_k,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_i,
    input  out_j,
    input  out_k,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/array_3d_serializer_index_counter.sv
// Three cascaded wrapping counters (k inner, i outer)
// with clear, advance and wrap/last flags.
module array_3d_index_counter #(
  parameter int DIM_I = array_3d_pkg::DIM_I,
  parameter int DIM_J = array_3d_pkg::DIM_J,
  parameter int DIM_K = array_3d_pkg::DIM_K,
  localparam int IW = array_3d_pkg::idx_w(DIM_I),
  localparam int JW = array_3d_pkg::idx_w(DIM_J),
  localparam int KW = array_3d_pkg::idx_w(DIM_K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [IW-1:0] i_o,
  output logic [JW-1:0] j_o,
  output logic [KW-1:0] k_o,
  output logic          k_wrap_o,
  output logic          j_wrap_o,
  output logic          last_o
);

  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic          i_end, j_end, k_end;

  assign i_end = (i_q == IW'(DIM_I - 1));
  assign j_end = (j_q == JW'(DIM_J - 1));
  assign k_end = (k_q == KW'(DIM_K - 1));

  assign k_wrap_o = k_end;
  assign j_wrap_o = k_end & j_end;
  assign last_o   = k_end & j_end & i_end;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (adv_i) begin
      k_d = k_end ? '0 : k_q + KW'(1);
      if (k_end) begin
        j_d = j_end ? '0 : j_q + JW'(1);
        if (j_end)
          i_d = i_end ? '0 : i_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i_o = i_q;
  assign j_o = j_q;
  assign k_o = k_q;

endmodule

// File: rtl/array_3d_serializer.sv
// Snapshots a 3D array on start and streams it i/j/k-ordered.
// ARRAY_3D_SERIALIZER_CHECKSUM_EN adds a running checksum output.
module array_3d_serializer #(
  parameter int DIM_I = array_3d_pkg::DIM_I,
  parameter int DIM_J = array_3d_pkg::DIM_J,
  parameter int DIM_K = array_3d_pkg::DIM_K,
  parameter int DW    = array_3d_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] array_in [DIM_I][DIM_J][DIM_K],
  output logic          busy,
  output logic          done,
  array_3d_serializer_if.master out
`ifdef ARRAY_3D_SERIALIZER_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  import array_3d_pkg::*;

  localparam int IW = idx_w(DIM_I);
  localparam int JW = idx_w(DIM_J);
  localparam int KW = idx_w(DIM_K);

  state_e        state_q, state_d;
  logic [DW-1:0] snap_q [DIM_I][DIM_J][DIM_K];
  logic [IW-1:0] ci;
  logic [JW-1:0] cj;
  logic [KW-1:0] ck;
  logic          k_wrap, j_wrap, last;
  logic          accept, valid, xfer;
  logic [DW-1:0] data;

  assign accept = (state_q == IDLE) && start;
  assign xfer   = valid && out.out_ready;

  array_3d_index_counter #(
    .DIM_I (DIM_I),
    .DIM_J (DIM_J),
    .DIM_K (DIM_K)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept),
    .adv_i    (xfer),
    .i_o      (ci),
    .j_o      (cj),
    .k_o      (ck),
    .k_wrap_o (k_wrap),
    .j_wrap_o (j_wrap),
    .last_o   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Snapshot needs no reset: it is only read in STREAM.
  always_ff @(posedge clk) begin
    if (accept) snap_q <= array_in;
  end

  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = STREAM;
      end
      STREAM: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (out.out_ready && last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data = valid ? snap_q[ci][cj][ck] : '0;

  assign out.out_valid = valid;
  assign out.out_data  = data;
  assign out.out_i     = ci;
  assign out.out_j     = cj;
  assign out.out_k     = ck;
  assign out.out_last  = valid & last;

`ifdef ARRAY_3D_SERIALIZER_CHECKSUM_EN
  logic [DW-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sum_q <= '0;
    else if (accept) sum_q <= '0;
    else if (xfer)   sum_q <= sum_q + data;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_array_3d_serializer.sv
// Directed bench for array_3d_serializer with a
// beat scoreboard filled when start is accepted.
module tb_array_3d_serializer;

  import array_3d_pkg::*;

  localparam int IW = idx_w(DIM_I);
  localparam int JW = idx_w(DIM_J);
  localparam int KW = idx_w(DIM_K);
  localparam int NB = DIM_I * DIM_J * DIM_K;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [DW-1:0] src [DIM_I][DIM_J][DIM_K];
`ifdef ARRAY_3D_SERIALIZER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  array_3d_serializer_if #(
    .DW (DW), .IW (IW), .JW (JW), .KW (KW)
  ) bus ();

  array_3d_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .array_in (src),
    .busy     (busy),
    .done     (done),
    .out      (bus)
`ifdef ARRAY_3D_SERIALIZER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  beat_t         exq[$];
  beat_t         held;
  bit            hold_pend;
  bit            last_xfer_prev;
  bit            v_smp;
  int            nerr, nchk, beats, dones, b_start;
  logic [DW-1:0] exp_sum;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < DIM_I; i++)
      for (int j = 0; j < DIM_J; j++)
        for (int k = 0; k < DIM_K; k++)
          src[i][j][k] = DW'(i + j + k);
  endtask

  task automatic fill_ones();
    for (int i = 0; i < DIM_I; i++)
      for (int j = 0; j < DIM_J; j++)
        for (int k = 0; k < DIM_K; k++)
          src[i][j][k] = '1;
  endtask

  task automatic push_all();
    beat_t b;
    b_start = beats;
    exp_sum = '0;
    for (int i = 0; i < DIM_I; i++)
      for (int j = 0; j < DIM_J; j++)
        for (int k = 0; k < DIM_K; k++) begin
          b.d = src[i][j][k];
          b.i = IW'(i);
          b.j = JW'(j);
          b.k = KW'(k);
          b.l = (i == DIM_I-1) && (j == DIM_J-1) && (k == DIM_K-1);
          exp_sum = exp_sum + b.d;
          exq.push_back(b);
        end
  endtask

  // Sample at negedge, then drive inputs for the next posedge.
  task automatic tick(input logic rdy, input logic st);
    beat_t cur, e;
    @(negedge clk);
    cur = '{bus.out_data, bus.out_i, bus.out_j, bus.out_k,
            bus.out_last};
    v_smp = bus.out_valid;
    if (hold_pend) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_hold", cur, held);
    end
    if (done) begin
      dones++;
      chk("done_after_last", last_xfer_prev, 1);
      chk("done_busy_low", busy, 0);
    end
    if (bus.out_valid) chk("busy_in_stream", busy, 1);
    bus.out_ready = rdy;
    start = st;
    if (st && !busy && !done && !bus.out_valid) push_all();
    last_xfer_prev = 1'b0;
    hold_pend = bus.out_valid && !rdy;
    held = cur;
    if (bus.out_valid && rdy) begin
      chk("queue_nonempty", exq.size() != 0, 1);
      if (exq.size() != 0) begin
        e = exq.pop_front();
        chk("beat", cur, e);
      end
      beats++;
      last_xfer_prev = cur.l;
    end
  endtask

  task automatic run_until_done(input int mode, input int poke,
                                input bit st_all);
    int d0;
    logic rdy, st;
    d0 = dones;
    for (int c = 0; c < 400 && dones == d0; c++) begin
      rdy = (mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
      st = st_all || (poke >= 0 && beats - b_start == poke);
      tick(rdy, st);
    end
    chk("done_seen", dones - d0, 1);
    chk("beat_count", beats - b_start, NB);
    chk("queue_empty", exq.size(), 0);
`ifdef ARRAY_3D_SERIALIZER_CHECKSUM_EN
    chk("checksum", checksum, exp_sum);
`endif
    tick(1'b1, 1'b0);
    chk("done_one_cycle", done, 0);
    chk("idle_valid", bus.out_valid, 0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    fill_pattern();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_coord", {bus.out_i, bus.out_j, bus.out_k}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-rate stream
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    chk("first_beat_latency", v_smp, 1);
    run_until_done(0, -1, 1'b0);
`ifdef ARRAY_3D_SERIALIZER_CHECKSUM_EN
    chk("checksum_72", checksum, 72);
`endif

    // Backpressure 1,0,0,1
    tick(1'b1, 1'b1);
    run_until_done(1, -1, 1'b0);

    // Source changes after snapshot
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    fill_ones();
    run_until_done(0, -1, 1'b0);
    fill_pattern();

    // Start pulse on the 5th beat
    tick(1'b1, 1'b1);
    run_until_done(0, 4, 1'b0);
    repeat (3) begin
      tick(1'b1, 1'b0);
      chk("no_second_stream", bus.out_valid, 0);
    end

    // Start held high through stream and the done cycle
    tick(1'b1, 1'b1);
    run_until_done(0, -1, 1'b1);
    repeat (2) begin
      tick(1'b1, 1'b0);
      chk("start_not_queued", bus.out_valid, 0);
    end

    // Abort with reset after beat 10
    tick(1'b1, 1'b1);
    for (int c = 0; c < 100 && beats - b_start < 10; c++)
      tick(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_coord", {bus.out_i, bus.out_j, bus.out_k}, 0);
    exq.delete();
    hold_pend = 1'b0;
    last_xfer_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    chk("post_abort_idle", bus.out_valid, 0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    chk("restart_latency", v_smp, 1);
    run_until_done(1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
